// File: rtl/ev22_exec_unit.sv
// ev22_exec_unit: execution stage feeding the register bank write port.
// Single-cycle ADD/SUB/logic/MOV; multi-cycle shifts (1 bit/cycle) and
// shift-add MUL, sequenced by a start/busy/done handshake.
// Ports: clk, nreset (sync, active low), start, op, Data_A, Data_B, dest
// in; busy, done, illegal, Data_C, Sel_C, flag_z/n/c/v out.
module ev22_exec_unit #(
    parameter int WIDTH       = 16,
    parameter int SEL_W       = 6,
    parameter int SCRATCH_SEL = 34
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] Data_A,
    input  logic [WIDTH-1:0] Data_B,
    input  logic [SEL_W-1:0] dest,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] Data_C,
    output logic [SEL_W-1:0] Sel_C,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [SEL_W-1:0] SCR = SEL_W'(SCRATCH_SEL);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_SAR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [SEL_W-1:0]     dest_q, dest_d;
    // Shift working register, or multiplicand (widened) during MUL.
    logic [2*WIDTH-1:0]   wrk_q, wrk_d;
    logic [WIDTH-1:0]     mlt_q, mlt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ill_q, ill_d;
    logic [WIDTH-1:0]     data_c_q, data_c_d;
    logic                 z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

    logic [WIDTH:0]       sum, diff;
    logic [WIDTH-1:0]     sh_w;
    logic                 sh_c;
    logic [2*WIDTH-1:0]   mac;
    logic                 fin, fin_c, fin_v, fin_ill;
    logic [WIDTH-1:0]     fin_r;

    // One shift iteration on the low half of the working register.
    always_comb begin
        sh_w = wrk_q[WIDTH-1:0];
        sh_c = 1'b0;
        unique case (op_q)
            OP_SHL: begin
                sh_w = {wrk_q[WIDTH-2:0], 1'b0};
                sh_c = wrk_q[WIDTH-1];
            end
            OP_SHR: begin
                sh_w = {1'b0, wrk_q[WIDTH-1:1]};
                sh_c = wrk_q[0];
            end
            OP_SAR: begin
                sh_w = {wrk_q[WIDTH-1], wrk_q[WIDTH-1:1]};
                sh_c = wrk_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dest_d   = dest_q;
        wrk_d    = wrk_q;
        mlt_d    = mlt_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ill_d    = ill_q;
        data_c_d = data_c_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        fin      = 1'b0;
        fin_r    = '0;
        fin_c    = 1'b0;
        fin_v    = 1'b0;
        fin_ill  = 1'b0;
        sum      = {1'b0, Data_A} + {1'b0, Data_B};
        diff     = {1'b0, Data_A} - {1'b0, Data_B};
        mac      = acc_q + (mlt_q[0] ? wrk_q : '0);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    dest_d = dest;
                    wrk_d  = {{WIDTH{1'b0}}, Data_A};
                    mlt_d  = Data_B;
                    acc_d  = '0;
                    unique case (op)
                        OP_ADD: begin
                            fin   = 1'b1;
                            fin_r = sum[WIDTH-1:0];
                            fin_c = sum[WIDTH];
                            fin_v = (Data_A[WIDTH-1] == Data_B[WIDTH-1]) &&
                                    (sum[WIDTH-1] != Data_A[WIDTH-1]);
                        end
                        OP_SUB: begin
                            fin   = 1'b1;
                            fin_r = diff[WIDTH-1:0];
                            fin_c = diff[WIDTH];
                            fin_v = (Data_A[WIDTH-1] != Data_B[WIDTH-1]) &&
                                    (diff[WIDTH-1] != Data_A[WIDTH-1]);
                        end
                        OP_AND: begin fin = 1'b1; fin_r = Data_A & Data_B; end
                        OP_OR:  begin fin = 1'b1; fin_r = Data_A | Data_B; end
                        OP_XOR: begin fin = 1'b1; fin_r = Data_A ^ Data_B; end
                        OP_NOT: begin fin = 1'b1; fin_r = ~Data_A; end
                        OP_MOV: begin fin = 1'b1; fin_r = Data_B; end
                        OP_SHL, OP_SHR, OP_SAR: begin
                            if (Data_B[3:0] == 4'd0) begin
                                fin   = 1'b1;
                                fin_r = Data_A;
                            end else begin
                                cnt_d   = CW'(Data_B[3:0]);
                                state_d = S_RUN;
                            end
                        end
                        OP_MUL: begin
                            cnt_d   = CW'(WIDTH);
                            state_d = S_RUN;
                        end
                        default: begin
                            fin     = 1'b1;
                            fin_ill = 1'b1;
                        end
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = mac;
                    wrk_d = wrk_q << 1;
                    mlt_d = mlt_q >> 1;
                    if (cnt_q == CW'(1)) begin
                        fin   = 1'b1;
                        fin_r = mac[WIDTH-1:0];
                        fin_c = |mac[2*WIDTH-1:WIDTH];
                    end
                end else begin
                    wrk_d = {{WIDTH{1'b0}}, sh_w};
                    if (cnt_q == CW'(1)) begin
                        fin   = 1'b1;
                        fin_r = sh_w;
                        fin_c = sh_c;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ill_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Result and flags are registered as DONE is entered so they are
        // valid throughout the done cycle; illegal ops leave flags alone.
        if (fin) begin
            state_d = S_DONE;
            ill_d   = fin_ill;
            if (fin_ill) begin
                data_c_d = '0;
            end else begin
                data_c_d = fin_r;
                z_d      = (fin_r == '0);
                n_d      = fin_r[WIDTH-1];
                c_d      = fin_c;
                v_d      = fin_v;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            dest_q   <= '0;
            wrk_q    <= '0;
            mlt_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ill_q    <= 1'b0;
            data_c_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dest_q   <= dest_d;
            wrk_q    <= wrk_d;
            mlt_q    <= mlt_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ill_q    <= ill_d;
            data_c_q <= data_c_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
            v_q      <= v_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign illegal = done & ill_q;
    assign Sel_C   = (done && !ill_q) ? dest_q : SCR;
    assign Data_C  = data_c_q;
    assign flag_z  = z_q;
    assign flag_n  = n_q;
    assign flag_c  = c_q;
    assign flag_v  = v_q;
endmodule

// File: tb/tb_ev22_exec_unit.sv
// tb_ev22_exec_unit: directed self-checking bench for ev22_exec_unit.
// One task per scenario, inline comparisons, single summary line.
module tb_ev22_exec_unit;
    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] Data_A = '0;
    logic [15:0] Data_B = '0;
    logic [5:0]  dest = '0;
    logic        busy, done, illegal;
    logic [15:0] Data_C;
    logic [5:0]  Sel_C;
    logic        flag_z, flag_n, flag_c, flag_v;

    int checks = 0;
    int errors = 0;

    ev22_exec_unit dut (
        .clk(clk), .nreset(nreset), .start(start), .op(op),
        .Data_A(Data_A), .Data_B(Data_B), .dest(dest),
        .busy(busy), .done(done), .illegal(illegal),
        .Data_C(Data_C), .Sel_C(Sel_C),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    // Issue one op and wait (bounded) for done; returns in the done cycle.
    task automatic run_op(input logic [3:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [5:0] d,
                          output int lat);
        @(posedge clk); #1;
        start = 1'b1; op = o; Data_A = a; Data_B = b; dest = d;
        @(posedge clk); #1;
        start = 1'b0; Data_A = 16'hDEAD; Data_B = 16'hBEEF; dest = 6'd63;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout op=%0d: no done within %0d cycles", o, lat);
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        checks++;
        if ({busy, done, illegal} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 000", {busy, done, illegal});
        end
        checks++;
        if (Sel_C !== 6'd34 || Data_C !== 16'h0) begin
            errors++;
            $display("FAIL reset_out: Sel_C=%0d Data_C=%h want 34/0000", Sel_C, Data_C);
        end
        checks++;
        if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {flag_z, flag_n, flag_c, flag_v});
        end
    endtask

    task automatic test_add_sub();
        int lat;
        run_op(4'd0, 16'h7FFF, 16'h0001, 6'd5, lat);
        checks++;
        if (lat !== 1 || Data_C !== 16'h8000 || Sel_C !== 6'd5 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL add_res: lat=%0d C=%h sel=%0d ill=%b want 1/8000/5/0",
                     lat, Data_C, Sel_C, illegal);
        end
        checks++;
        if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0101) begin
            errors++;
            $display("FAIL add_flags: zncv=%b want 0101",
                     {flag_z, flag_n, flag_c, flag_v});
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || Sel_C !== 6'd34 || Data_C !== 16'h8000) begin
            errors++;
            $display("FAIL add_after: done=%b sel=%0d C=%h want 0/34/8000",
                     done, Sel_C, Data_C);
        end
        run_op(4'd1, 16'd3, 16'd5, 6'd7, lat);
        checks++;
        if (lat !== 1 || Data_C !== 16'hFFFE || Sel_C !== 6'd7) begin
            errors++;
            $display("FAIL sub_res: lat=%0d C=%h sel=%0d want 1/fffe/7",
                     lat, Data_C, Sel_C);
        end
        checks++;
        if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0110) begin
            errors++;
            $display("FAIL sub_flags: zncv=%b want 0110",
                     {flag_z, flag_n, flag_c, flag_v});
        end
    endtask

    task automatic test_logic();
        int lat;
        run_op(4'd4, 16'hF0F0, 16'hFF00, 6'd2, lat);
        checks++;
        if (Data_C !== 16'h0FF0 || {flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
            errors++;
            $display("FAIL xor: C=%h zncv=%b want 0ff0/0000",
                     Data_C, {flag_z, flag_n, flag_c, flag_v});
        end
        run_op(4'd5, 16'hFFFF, 16'h1234, 6'd3, lat);
        checks++;
        if (Data_C !== 16'h0000 || flag_z !== 1'b1) begin
            errors++;
            $display("FAIL not: C=%h z=%b want 0000/1", Data_C, flag_z);
        end
    endtask

    task automatic test_shift();
        int lat;
        run_op(4'd7, 16'h0001, 16'd15, 6'd9, lat);
        checks++;
        if (lat !== 16 || Data_C !== 16'h8000 || flag_c !== 1'b0 || Sel_C !== 6'd9) begin
            errors++;
            $display("FAIL shl15: lat=%0d C=%h c=%b sel=%0d want 16/8000/0/9",
                     lat, Data_C, flag_c, Sel_C);
        end
        run_op(4'd9, 16'h8000, 16'd4, 6'd9, lat);
        checks++;
        if (lat !== 5 || Data_C !== 16'hF800 || flag_n !== 1'b1) begin
            errors++;
            $display("FAIL sar4: lat=%0d C=%h n=%b want 5/f800/1",
                     lat, Data_C, flag_n);
        end
        run_op(4'd8, 16'h0003, 16'd1, 6'd9, lat);
        checks++;
        if (lat !== 2 || Data_C !== 16'h0001 || flag_c !== 1'b1) begin
            errors++;
            $display("FAIL shr1: lat=%0d C=%h c=%b want 2/0001/1",
                     lat, Data_C, flag_c);
        end
        run_op(4'd8, 16'h0003, 16'd0, 6'd9, lat);
        checks++;
        if (lat !== 1 || Data_C !== 16'h0003 || flag_c !== 1'b0) begin
            errors++;
            $display("FAIL shr0: lat=%0d C=%h c=%b want 1/0003/0",
                     lat, Data_C, flag_c);
        end
    endtask

    task automatic test_mul();
        int lat;
        run_op(4'd10, 16'd300, 16'd300, 6'd31, lat);
        checks++;
        if (lat !== 17 || Data_C !== 16'h5F90 || flag_c !== 1'b1 || Sel_C !== 6'd31) begin
            errors++;
            $display("FAIL mul300: lat=%0d C=%h c=%b sel=%0d want 17/5f90/1/31",
                     lat, Data_C, flag_c, Sel_C);
        end
        run_op(4'd10, 16'h0000, 16'hFFFF, 6'd31, lat);
        checks++;
        if (Data_C !== 16'h0000 || flag_z !== 1'b1 || flag_c !== 1'b0) begin
            errors++;
            $display("FAIL mul0: C=%h z=%b c=%b want 0000/1/0",
                     Data_C, flag_z, flag_c);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; op = 4'd10; Data_A = 16'd300; Data_B = 16'd300; dest = 6'd31;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (cyc == 5) begin
                start = 1'b1; op = 4'd0; Data_A = 16'd1; Data_B = 16'd1; dest = 6'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (cyc !== 17 || Data_C !== 16'h5F90 || Sel_C !== 6'd31) begin
            errors++;
            $display("FAIL busy_ignore: cyc=%0d C=%h sel=%0d want 17/5f90/31",
                     cyc, Data_C, Sel_C);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || Sel_C !== 6'd34) begin
            errors++;
            $display("FAIL no_queue: done=%b busy=%b sel=%0d want 0/0/34",
                     done, busy, Sel_C);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        @(posedge clk); #1;
        start = 1'b1; op = 4'd10; Data_A = 16'd300; Data_B = 16'd300; dest = 6'd31;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        nreset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Sel_C !== 6'd34 || Data_C !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b sel=%0d C=%h want 0/0/34/0000",
                     busy, done, Sel_C, Data_C);
        end
        nreset = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_nodone: dones=%0d want 0", dones);
        end
    endtask

    task automatic test_illegal();
        int lat;
        run_op(4'd1, 16'd3, 16'd5, 6'd7, lat);
        run_op(4'd12, 16'h1234, 16'h5678, 6'd8, lat);
        checks++;
        if (lat !== 1 || illegal !== 1'b1 || Sel_C !== 6'd34 || Data_C !== 16'h0) begin
            errors++;
            $display("FAIL illegal: lat=%0d ill=%b sel=%0d C=%h want 1/1/34/0000",
                     lat, illegal, Sel_C, Data_C);
        end
        checks++;
        if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0110) begin
            errors++;
            $display("FAIL illegal_flags: zncv=%b want 0110 held",
                     {flag_z, flag_n, flag_c, flag_v});
        end
        @(posedge clk); #1;
        checks++;
        if (illegal !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse: ill=%b done=%b want 0/0", illegal, done);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_mul();
        test_back_to_back();
        test_reset_mid();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ev22_exec_unit.md
Name: ev22_exec_unit

Overview:
- Execution stage directly downstream of the 16-bit register bank. Consumes the two read operands Data_A/Data_B and produces a write-back result with a write-back select (Data_C/Sel_C) that feeds the bank's write port.
- Single-cycle ops: ADD, SUB, logic, MOV.
- Multi-cycle ops, sequenced by a start/busy/done handshake with the control unit: shifts (one bit per cycle) and MUL (shift-add, 16 cycles).

Parameters:
- WIDTH, 16, datapath width; must match the register bank.
- SEL_W, 6, write-back select width.
- SCRATCH_SEL, 34, select driven whenever no write-back is intended; the bank's scratch register.

Ports:
- clk  in  1  rising-edge clock
- nreset  in  1  synchronous active-low reset, sampled on the clk rising edge
- start  in  1  request; accepted only in IDLE
- op  in  4  operation code, captured with start
- Data_A  in  WIDTH  operand A from the register bank
- Data_B  in  WIDTH  operand B from the register bank; shift amount in Data_B[3:0]
- dest  in  SEL_W  destination select, captured with start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result and flags valid this cycle
- illegal  out  1  one-cycle pulse with done for an undefined op
- Data_C  out  WIDTH  result to the bank write port
- Sel_C  out  SEL_W  write-back select: dest on the done cycle, SCRATCH_SEL otherwise
- flag_z, flag_n, flag_c, flag_v  out  1 each  status flags, updated on done, held otherwise

Behaviour:
- Reset: synchronous, nreset low at a clk edge.
  - state=IDLE.
  - busy, done, illegal = 0.
  - Data_C = 0; Sel_C = SCRATCH_SEL; all flags = 0; internal counter and accumulators = 0.
  - Reset overrides any in-flight operation; the result is discarded and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, capture op, Data_A, Data_B, dest.
  - Single-cycle op, shift with amount 0, or illegal op: go to DONE.
  - Shift with amount n>0: load counter=n, go to RUN.
  - MUL: load counter=16, go to RUN.
- RUN:
  - Each cycle, decrement the counter and perform one iteration.
  - Shift: 1-bit shift of the working register; record the bit shifted out.
  - MUL: if multiplier LSB=1, accumulate multiplicand into a 32-bit product; shift multiplicand left and multiplier right.
  - When the counter reaches 1 on this cycle, go to DONE.
- DONE:
  - done=1; Data_C=result; Sel_C=dest; flags update.
  - Unconditionally go to IDLE next cycle.
- Latency from the start edge to done:
  - 1 cycle for single-cycle ops.
  - n+1 cycles for a shift by n.
  - 17 cycles for MUL.
- start while busy=1 is ignored; no queuing. Operands must be held stable only on the start cycle.
- Opcodes and results:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND, 3 OR, 4 XOR.
  - 5 NOT: ~A.
  - 6 MOV: B.
  - 7 SHL, 8 SHR (logical), 9 SAR (arithmetic): shifts of A.
  - 10 MUL: low 16 bits of A*B, unsigned.
  - 11-15 illegal: Data_C=0, Sel_C=SCRATCH_SEL on the done cycle, illegal=1, flags unchanged.
- Flags:
  - Z = (result==0); N = result[15].
  - C: ADD carry-out; SUB borrow (1 when A<B unsigned); shifts the last bit shifted out (0 if amount=0); MUL 1 if upper 16 product bits are nonzero; 0 for logic/NOT/MOV.
  - V: signed overflow for ADD/SUB; 0 for all other ops.
- Outside the done cycle, Data_C holds its last value and Sel_C = SCRATCH_SEL. The bank therefore writes only the scratch register on non-done cycles.

Test Plan:
- Reset: nreset=0 for 2 cycles, then high -> busy=0, done=0, Sel_C=34, Data_C=0, all flags 0.
- ADD A=0x7FFF, B=0x0001, dest=5 -> done exactly 1 cycle after start, Data_C=0x8000, Sel_C=5, N=1, V=1, C=0, Z=0. SUB A=3, B=5 -> 0xFFFE, C=1, N=1, V=0.
- SHL A=0x0001, B=15 -> busy for 16 cycles, done at cycle 16, Data_C=0x8000, C=0. SAR A=0x8000, B=4 -> 0xF800. SHR A=0x0003, B=0 -> done at cycle 1, Data_C=0x0003, C=0.
- MUL A=300, B=300, dest=31 -> done at cycle 17, Data_C=0x5F90, C=1, Sel_C=31. MUL A=0, B=0xFFFF -> 0x0000, Z=1, C=0.
- During MUL, pulse start with op=ADD at cycle 5 -> ignored, MUL result unchanged. Drop nreset at cycle 8 -> IDLE next edge, no done, Sel_C=34.
- op=12 -> done and illegal high together 1 cycle after start, Sel_C=34, Data_C=0, flags held from the previous op.
